// File: rtl/gpio_param_sequencer_if.sv
// Bus bundle between the host register bank and the GPIO parameter-set sequencer.
// The host side (master) drives control and configuration, the sequencer (slave)
// returns the set select, step index and status pulses.
interface gpio_param_sequencer_if #(
   parameter int SEQ_DEPTH   = 16,
   parameter int DWELL_WIDTH = 24
);
   logic                     start;
   logic                     stop;
   logic                     pause;
   logic                     loop;
   logic [4*SEQ_DEPTH-1:0]   seq_table;
   logic [3:0]               seq_len;
   logic [DWELL_WIDTH-1:0]   dwell;
   logic [3:0]               set_sel;
   logic [3:0]               step_idx;
   logic                     step_strobe;
   logic                     busy;
   logic                     done;

   modport master (
      output start, stop, pause, loop, seq_table, seq_len, dwell,
      input  set_sel, step_idx, step_strobe, busy, done
   );

   modport slave (
      input  start, stop, pause, loop, seq_table, seq_len, dwell,
      output set_sel, step_idx, step_strobe, busy, done
   );
endinterface

// File: rtl/gpio_param_sequencer.sv
// GPIO parameter-set sequencer: walks the 4-bit set select through a latched
// table of up to SEQ_DEPTH entries, holding each for max(dwell,1) cycles.
// Optional feature macro: GPIO_SEQ_LOOP_EN -- when defined, the loop input
// restarts the sequence at entry 0 instead of finishing with done.
//
//   state  | meaning
//   IDLE   | no sequence active, waiting for start
//   RUN    | dwell counter decrementing
//   PAUSED | dwell counter frozen while pause is high
module gpio_param_sequencer #(
   parameter int SEQ_DEPTH   = 16,
   parameter int DWELL_WIDTH = 24
) (
   input logic                 clk,
   input logic                 rst_n,
   gpio_param_sequencer_if.slave bus
);

`ifdef GPIO_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   localparam logic [3:0] LEN_MAX = 4'(SEQ_DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t                       state, state_nx;
   logic [DWELL_WIDTH-1:0]       cnt, cnt_nx;
   logic [DWELL_WIDTH-1:0]       dwell_q, dwell_nx;
   logic [SEQ_DEPTH-1:0][3:0]    tbl_q, tbl_nx;
   logic [3:0]                   len_q, len_nx;
   logic [3:0]                   step_q, step_nx;
   logic [3:0]                   set_q, set_nx;
   logic                         strobe_q, strobe_nx;
   logic                         done_q, done_nx;
   logic                         loop_ok;

   // With looping compiled out the loop input folds away to constant 0.
   assign loop_ok = LOOP_EN & bus.loop;

   // State, counter, latched configuration and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         dwell_q  <= '0;
         tbl_q    <= '0;
         len_q    <= '0;
         step_q   <= '0;
         set_q    <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state    <= state_nx;
         cnt      <= cnt_nx;
         dwell_q  <= dwell_nx;
         tbl_q    <= tbl_nx;
         len_q    <= len_nx;
         step_q   <= step_nx;
         set_q    <= set_nx;
         strobe_q <= strobe_nx;
         done_q   <= done_nx;
      end
   end

   // Next-state decode; stop outranks both start and step expiry, and a
   // paused cycle with pause released counts as a normal run cycle so the
   // frozen value resumes without losing a cycle.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      dwell_nx  = dwell_q;
      tbl_nx    = tbl_q;
      len_nx    = len_q;
      step_nx   = step_q;
      set_nx    = set_q;
      strobe_nx = 1'b0;
      done_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               tbl_nx    = bus.seq_table;
               len_nx    = (bus.seq_len > LEN_MAX) ? LEN_MAX : bus.seq_len;
               dwell_nx  = (bus.dwell == '0) ? DWELL_WIDTH'(1) : bus.dwell;
               cnt_nx    = dwell_nx;
               step_nx   = 4'd0;
               set_nx    = bus.seq_table[3:0];
               strobe_nx = 1'b1;
               state_nx  = RUN;
            end
         end
         RUN, PAUSED: begin
            if (bus.stop) begin
               state_nx = IDLE;
            end else if (bus.pause) begin
               state_nx = PAUSED;
            end else begin
               state_nx = RUN;
               if (cnt > DWELL_WIDTH'(1)) begin
                  cnt_nx = cnt - DWELL_WIDTH'(1);
               end else if (step_q < len_q) begin
                  step_nx   = step_q + 4'd1;
                  set_nx    = tbl_q[step_nx];
                  cnt_nx    = dwell_q;
                  strobe_nx = 1'b1;
               end else if (loop_ok) begin
                  step_nx   = 4'd0;
                  set_nx    = tbl_q[0];
                  cnt_nx    = dwell_q;
                  strobe_nx = 1'b1;
               end else begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.set_sel     = set_q;
   assign bus.step_idx    = step_q;
   assign bus.step_strobe = strobe_q;
   assign bus.done        = done_q;
   assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_gpio_param_sequencer.sv
// Self-checking bench for gpio_param_sequencer. The driver computes, edge by
// edge, which advancing cycle completes each entry and queues the expected
// strobe/done events; an independent monitor pops and compares them.
module tb_gpio_param_sequencer;
   localparam int SEQ_DEPTH   = 16;
   localparam int DWELL_WIDTH = 24;

`ifdef GPIO_SEQ_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

   typedef struct {
      int         cyc;
      bit         is_done;
      logic [3:0] set_v;
      logic [3:0] step_v;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   ev_t  sb[$];
   ev_t  e;
   logic [3:0] prev_set = 4'd0;

   gpio_param_sequencer_if #(.SEQ_DEPTH(SEQ_DEPTH), .DWELL_WIDTH(DWELL_WIDTH)) bus ();

   gpio_param_sequencer #(.SEQ_DEPTH(SEQ_DEPTH), .DWELL_WIDTH(DWELL_WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   function automatic void push_ev(input int c, input bit d, input logic [3:0] s, input logic [3:0] st);
      ev_t x;
      x.cyc = c; x.is_done = d; x.set_v = s; x.step_v = st;
      sb.push_back(x);
   endfunction

   // Monitor: every strobe or done must match the head of the scoreboard; set
   // must never move without a strobe.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.step_strobe || bus.done) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_event: strobe=%0b done=%0b set=%0h at cycle %0d, expected none",
                        bus.step_strobe, bus.done, bus.set_sel, cyc);
            end else begin
               e = sb.pop_front();
               chk("event_cycle", cyc, e.cyc);
               chk("event_is_done", {31'd0, bus.done}, {31'd0, e.is_done});
               chk("event_strobe", {31'd0, bus.step_strobe}, {31'd0, !e.is_done});
               chk("event_set", {28'd0, bus.set_sel}, {28'd0, e.set_v});
               chk("event_step", {28'd0, bus.step_idx}, {28'd0, e.step_v});
            end
         end else begin
            chk("set_hold_without_strobe", {28'd0, bus.set_sel}, {28'd0, prev_set});
         end
      end
      prev_set = bus.set_sel;
   end

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_set"},    {28'd0, bus.set_sel},     32'd0);
      chk({tag, "_step"},   {28'd0, bus.step_idx},    32'd0);
      chk({tag, "_strobe"}, {31'd0, bus.step_strobe}, 32'd0);
      chk({tag, "_busy"},   {31'd0, bus.busy},        32'd0);
      chk({tag, "_done"},   {31'd0, bus.done},        32'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      end
   endtask

   // One sequence. Offsets i count edges from the start edge (i=0). Pause is
   // high for p_from <= i < p_to, loop is high for i < loop_until.
   task automatic run_seq(input logic [63:0] tbl, input logic [3:0] len, input logic [23:0] dw,
                          input int p_from, input int p_to, input int stop_at, input int loop_until,
                          input int glitch_at, input bit both, input int rst_at, input bit scramble);
      int  lm1, d, k, adv;
      bit  running, st, sp, pz, lp;
      lm1 = (int'(len) > SEQ_DEPTH - 1) ? SEQ_DEPTH - 1 : int'(len);
      d   = (dw == 24'd0) ? 1 : int'(dw);
      running = 1'b0;
      k = 0; adv = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i > 0 && !running) break;
         st = (i == 0) || (i == glitch_at);
         sp = (i == stop_at) || (i == 0 && both);
         pz = (i >= p_from) && (i < p_to);
         lp = (i < loop_until);
         if (i == 0) begin
            if (!sp) begin
               running = 1'b1;
               push_ev(cyc + 1, 1'b0, tbl[3:0], 4'd0);
            end
         end else if (sp) begin
            running = 1'b0;
         end else if (!pz) begin
            adv++;
            if (adv == d) begin
               adv = 0;
               if (k < lm1) begin
                  k++;
                  push_ev(cyc + 1, 1'b0, tbl[4*k +: 4], 4'(k));
               end else if (LOOP_EN && lp) begin
                  k = 0;
                  push_ev(cyc + 1, 1'b0, tbl[3:0], 4'd0);
               end else begin
                  running = 1'b0;
                  push_ev(cyc + 1, 1'b1, tbl[4*k +: 4], 4'(k));
               end
            end
         end
         bus.start = st;
         bus.stop  = sp;
         bus.pause = pz;
         bus.loop  = lp;
         if (i == 0) begin
            bus.seq_table = tbl;
            bus.seq_len   = len;
            bus.dwell     = dw;
         end else if (scramble) begin
            bus.seq_table = {$urandom, $urandom};
            bus.seq_len   = 4'($urandom);
            bus.dwell     = 24'($urandom_range(0, 9));
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.stop  = 1'b0;
         chk("busy", {31'd0, bus.busy}, {31'd0, running});
         if (i == rst_at) begin
            #2 rst_n = 1'b0;
            #1 check_zero_outputs("async_reset");
            sb.delete();
            running = 1'b0;
            @(posedge clk); #1 rst_n = 1'b1;
            break;
         end
      end
      bus.pause = 1'b0;
      if (running) begin
         checks++;
         errors++;
         $display("FAIL run_timeout: sequence still busy=%0b after cycle budget, expected 0", bus.busy);
      end
   endtask

   initial begin
      bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.loop = 1'b0;
      bus.seq_table = '0; bus.seq_len = '0; bus.dwell = '0;
      repeat (2) @(posedge clk);
      #1 check_zero_outputs("reset");
      rst_n = 1'b1;
      idle(2);

      // basic run {3,7,A} dwell 4, then a back-to-back start in the done cycle
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, -1, 0, -1, 1'b0, -1, 1'b1);
      chk("basic_final_set", {28'd0, bus.set_sel}, 32'hA);
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, -1, 0, -1, 1'b0, -1, 1'b0);
      idle(2);

      // dwell 0 with full depth
      run_seq(64'hFEDCBA9876543210, 4'hF, 24'd0, 1000, 1000, -1, 0, -1, 1'b0, -1, 1'b1);
      idle(1);

      // pause 5 cycles during entry 1
      run_seq(64'hA73, 4'd2, 24'd4, 5, 10, -1, 0, -1, 1'b0, -1, 1'b0);
      idle(1);
      // stop while paused in entry 1
      run_seq(64'hA73, 4'd2, 24'd4, 5, 40, 12, 0, -1, 1'b0, -1, 1'b0);
      chk("stop_in_pause_set", {28'd0, bus.set_sel}, 32'h7);
      idle(2);

      // start with stop in idle
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, -1, 0, -1, 1'b1, -1, 1'b0);
      idle(1);
      // stop on an expiry cycle, then on the final expiry
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, 4, 0, -1, 1'b0, -1, 1'b0);
      idle(1);
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, 12, 0, -1, 1'b0, -1, 1'b0);
      idle(1);
      // start during run is ignored
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, -1, 0, 6, 1'b0, -1, 1'b0);
      idle(1);

      // loop {1,2} dwell 2, loop dropped mid-run
      run_seq(64'h21, 4'd1, 24'd2, 1000, 1000, -1, 9, -1, 1'b0, -1, 1'b0);
      idle(1);

      // reset during entry 2, then a fresh start is accepted
      run_seq(64'hA73, 4'd2, 24'd4, 1000, 1000, -1, 0, -1, 1'b0, 9, 1'b0);
      run_seq(64'h5C, 4'd1, 24'd3, 1000, 1000, -1, 0, -1, 1'b0, -1, 1'b0);
      idle(1);

      // randomized runs
      for (int r = 0; r < 14; r++) begin
         int pf;
         pf = int'($urandom_range(1, 20));
         run_seq({$urandom, $urandom}, 4'($urandom_range(0, 15)), 24'($urandom_range(0, 5)),
                 pf, pf + int'($urandom_range(0, 6)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : -1,
                 int'($urandom_range(0, 25)), int'($urandom_range(1, 6)), 1'b0, -1, 1'b1);
         idle(int'($urandom_range(0, 2)));
      end

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
